// File: rtl/pulse_period_meter.sv
// Measures clk_in cycles between rising edges of an async pulse train; flags stalls.
// Latency: pin rise before edge k -> period_valid after edge k+SYNC_STAGES; no backpressure, strobe is single-cycle.
module pulse_period_meter #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             stalled,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s_q;
    logic                   rise;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       period_q;
    logic                   valid_q;
    logic                   stalled_q;
    logic                   busy_q;

    assign s_q  = sync_q[SYNC_STAGES-1];
    assign rise = s_q & ~prev_q;

    // Edge detector runs independently of enable so re-enabling on a high input sees no edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= s_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!enable) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                stalled_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ARM;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                    ARM: begin
                        if (rise) begin
                            state_q <= MEAS;
                            cnt_q   <= ONE_C;
                            busy_q  <= 1'b1;
                        end
                    end
                    MEAS: begin
                        // A rise landing on the timeout cycle is still a valid period.
                        if (rise) begin
                            period_q  <= cnt_q;
                            valid_q   <= 1'b1;
                            stalled_q <= 1'b0;
                            cnt_q     <= ONE_C;
                        end else if (cnt_q == TIMEOUT_C) begin
                            stalled_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ARM;
                            busy_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + ONE_C;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: periods, stall timeout, enable drop, async reset.
module tb_pulse_period_meter;

    localparam int CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             stalled;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    int seg_cyc;
    int sq_idx[$];
    int sq_val[$];
    bit stall_seen;

    pulse_period_meter #(.CNT_W(CNT_W), .TIMEOUT(200), .SYNC_STAGES(2)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .enable      (enable),
        .period_out  (period_out),
        .period_valid(period_valid),
        .stalled     (stalled),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic seg_start();
        seg_cyc = 0;
        sq_idx.delete();
        sq_val.delete();
        stall_seen = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (period_valid) begin
            sq_idx.push_back(seg_cyc);
            sq_val.push_back(int'(period_out));
        end
        if (stalled) stall_seen = 1'b1;
        seg_cyc++;
    endtask

    task automatic drive_sq(input int period, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = ((i % period) < (period / 2));
            tick();
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        seg_start();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; sig_in = 1'b0;
        seg_start();
        repeat (3) tick();
        n_tests++; if (period_out !== 8'd0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period_out); end
        n_tests++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", period_valid); end
        n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL reset_stalled: got %b want 0", stalled); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1; enable = 1'b1;
        seg_start();
        drive_sq(10, 35);
        n_tests++; if (sq_idx.size() !== 3) begin n_fail++; $display("FAIL pre_reset_strobes: got %0d want 3", sq_idx.size()); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({period_out, period_valid, stalled, busy} !== 11'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got p=%0d v=%b s=%b b=%b want all 0", period_out, period_valid, stalled, busy);
        end
        sig_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        seg_start();
        drive_sq(10, 13);
        n_tests++; if (sq_idx.size() !== 1) begin n_fail++; $display("FAIL post_reset_strobes: got %0d want 1", sq_idx.size()); end
        else begin
            n_tests++; if (sq_idx[0] !== 12) begin n_fail++; $display("FAIL post_reset_strobe_cyc: got %0d want 12", sq_idx[0]); end
            n_tests++; if (sq_val[0] !== 10) begin n_fail++; $display("FAIL post_reset_period: got %0d want 10", sq_val[0]); end
        end
    endtask

    task automatic test_min_period();
        restart();
        drive_sq(2, 20);
        n_tests++; if (sq_idx.size() !== 8) begin n_fail++; $display("FAIL min_strobe_count: got %0d want 8", sq_idx.size()); end
        else begin
            n_tests++; if (sq_idx[0] !== 4) begin n_fail++; $display("FAIL min_first_strobe: got %0d want 4", sq_idx[0]); end
            for (int k = 0; k < 8; k++) begin
                n_tests++; if (sq_val[k] !== 2) begin n_fail++; $display("FAIL min_period[%0d]: got %0d want 2", k, sq_val[k]); end
                n_tests++; if (sq_idx[k] !== 4 + 2 * k) begin n_fail++; $display("FAIL min_strobe_cyc[%0d]: got %0d want %0d", k, sq_idx[k], 4 + 2 * k); end
            end
        end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL min_busy: got %b want 1", busy); end
    endtask

    task automatic test_square();
        restart();
        drive_sq(10, 35);
        n_tests++; if (sq_idx.size() !== 3) begin n_fail++; $display("FAIL sq_strobe_count: got %0d want 3", sq_idx.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++; if (sq_idx[k] !== 12 + 10 * k) begin n_fail++; $display("FAIL sq_strobe_cyc[%0d]: got %0d want %0d", k, sq_idx[k], 12 + 10 * k); end
                n_tests++; if (sq_val[k] !== 10) begin n_fail++; $display("FAIL sq_period[%0d]: got %0d want 10", k, sq_val[k]); end
            end
        end
    endtask

    // Continues from test_square: last rise took effect at segment cycle 32.
    task automatic test_stall();
        sig_in = 1'b0;
        while (seg_cyc < 232) tick();
        n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL stall_early: got %b want 0 at 199 cycles", stalled); end
        tick();
        n_tests++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL stall_set: got %b want 1 at 200 cycles", stalled); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy: got %b want 0", busy); end
        n_tests++; if (period_out !== 8'd10) begin n_fail++; $display("FAIL stall_period_hold: got %0d want 10", period_out); end
        n_tests++; if (sq_idx.size() !== 3) begin n_fail++; $display("FAIL stall_no_strobe: got %0d strobes want 3", sq_idx.size()); end
        seg_start();
        drive_sq(10, 12);
        n_tests++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL resume_stalled_hold: got %b want 1", stalled); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL resume_busy: got %b want 1", busy); end
        n_tests++; if (sq_idx.size() !== 0) begin n_fail++; $display("FAIL resume_arm_strobe: got %0d want 0", sq_idx.size()); end
        tick();
        n_tests++; if (sq_idx.size() !== 1) begin n_fail++; $display("FAIL resume_strobe: got %0d want 1", sq_idx.size()); end
        n_tests++; if (period_out !== 8'd10) begin n_fail++; $display("FAIL resume_period: got %0d want 10", period_out); end
        n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL resume_stall_clear: got %b want 0", stalled); end
    endtask

    task automatic test_timeout_edge();
        restart();
        drive_sq(200, 403);
        n_tests++; if (sq_idx.size() !== 2) begin n_fail++; $display("FAIL to_strobe_count: got %0d want 2", sq_idx.size()); end
        else begin
            n_tests++; if (sq_idx[0] !== 202) begin n_fail++; $display("FAIL to_strobe_cyc: got %0d want 202", sq_idx[0]); end
            n_tests++; if (sq_val[0] !== 200) begin n_fail++; $display("FAIL to_period0: got %0d want 200", sq_val[0]); end
            n_tests++; if (sq_val[1] !== 200) begin n_fail++; $display("FAIL to_period1: got %0d want 200", sq_val[1]); end
        end
        n_tests++; if (stall_seen !== 1'b0) begin n_fail++; $display("FAIL to_stalled: got %b want 0", stall_seen); end
    endtask

    task automatic test_enable_drop();
        restart();
        drive_sq(12, 28);
        n_tests++; if (sq_val.size() !== 2 || period_out !== 8'd12) begin
            n_fail++; $display("FAIL en_setup: got %0d strobes p=%0d want 2 p=12", sq_val.size(), period_out);
        end
        seg_start();
        enable = 1'b0;
        sig_in = 1'b1;
        repeat (5) tick();
        enable = 1'b1;
        repeat (4) tick();
        n_tests++; if (sq_idx.size() !== 0) begin n_fail++; $display("FAIL en_spurious: got %0d strobes want 0", sq_idx.size()); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_busy_arm: got %b want 0", busy); end
        n_tests++; if (period_out !== 8'd12) begin n_fail++; $display("FAIL en_hold: got %0d want 12", period_out); end
        sig_in = 1'b0;
        repeat (3) tick();
        seg_start();
        drive_sq(8, 10);
        n_tests++; if (sq_idx.size() !== 0) begin n_fail++; $display("FAIL en_rearm_strobe: got %0d want 0", sq_idx.size()); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL en_busy_meas: got %b want 1", busy); end
        n_tests++; if (period_out !== 8'd12) begin n_fail++; $display("FAIL en_hold2: got %0d want 12", period_out); end
        tick();
        n_tests++; if (period_valid !== 1'b1 || period_out !== 8'd8) begin
            n_fail++; $display("FAIL en_new_period: got v=%b p=%0d want v=1 p=8", period_valid, period_out);
        end
    endtask

    initial begin
        test_reset();
        test_min_period();
        test_square();
        test_stall();
        test_timeout_edge();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Receive-side counterpart to the fan controller's clock divider. Samples a slow pulse train (a divided clock or fan tach line) in the clk_in domain and synchronises it. Measures the number of clk_in cycles between consecutive rising edges, reports each period with a one-cycle valid strobe, and flags a stalled input when no edge arrives within a timeout.

Parameters:
CNT_W, 8, width of period counter and period_out
TIMEOUT, 200, cycles without a rising edge before stalled; legal range 2 .. 2^CNT_W-1
SYNC_STAGES, 2, flops in input synchroniser chain; minimum 2

Ports:
clk_in  input  1  system clock (100 Hz in fan controller)
rst_n  input  1  asynchronous reset, active low
sig_in  input  1  asynchronous pulse train to measure
enable  input  1  measurement enable, level
period_out  output  CNT_W  last measured period in clk_in cycles
period_valid  output  1  one-cycle strobe: period_out updated this cycle
stalled  output  1  no rising edge seen for TIMEOUT cycles while measuring
busy  output  1  FSM in MEAS state

Behaviour:
- Interface: one clock, clk_in. Reset rst_n is asynchronous, active low.
- Reset: sync chain, edge register and counter = 0; FSM = IDLE; period_out = 0; period_valid = 0; stalled = 0; busy = 0.
- Synchroniser: sig_in passes through SYNC_STAGES flops to give s_q. prev_q registers s_q.
- rise = s_q & ~prev_q.
- Synchroniser and prev_q run regardless of enable, so re-enabling never produces a false edge.
- Latency: sig_in rising before clk edge k gives period_valid high in the cycle after edge k+SYNC_STAGES.
- FSM states: IDLE, ARM, MEAS.
- IDLE: counter held at 0. enable=1 moves to ARM.
- ARM: waits for the first rise. On rise: counter <= 1, move to MEAS, no strobe.
- MEAS: each cycle without rise, counter <= counter+1.
- MEAS on rise: period_out <= counter, period_valid <= 1 for exactly one cycle, stalled <= 0, counter <= 1, stay in MEAS.
- Timeout: in MEAS with counter == TIMEOUT and no rise: stalled <= 1, counter <= 0, move to ARM, no strobe. period_out is held.
- Rise in the same cycle as counter == TIMEOUT: the rise wins. Period TIMEOUT is reported and stalled is not set.
- Counter never exceeds TIMEOUT, so no wrap or saturation is possible.
- enable=0 in any state: next state IDLE, counter <= 0, stalled <= 0, no strobe. period_out is held.
- A rise coincident with enable falling is ignored.
- busy = (state == MEAS), registered.
- Minimum reportable period is 2: input toggling every clk_in cycle.
- Input faster than clk_in/2 is aliased. This is not checked.
- Reset mid-operation: all outputs return to reset values asynchronously. The first rise after reset release is treated as an ARM edge.

Test Plan:
1. rst_n low 3 cycles, then sig_in toggling, enable=1; pulse rst_n low mid-measurement -> all outputs 0 immediately; after release, first edge gives no strobe, second edge gives a strobe.
2. enable=1, sig_in toggled every clk_in cycle (50 Hz from 100 Hz) -> first rise gives no strobe; then period_valid every 2 cycles with period_out=2; valid pulses are single-cycle.
3. sig_in square wave, period 10 cycles -> period_out=10 each strobe; first strobe 10 cycles after the first detected rise (+SYNC_STAGES latency from the pin).
4. After 3 good periods of 10, hold sig_in low (TIMEOUT=200) -> stalled=1 exactly 200 cycles after the last rise; period_out stays 10; busy=0. Resume the 10-cycle wave -> stalled clears on the second rise with period_out=10.
5. Rises spaced exactly 200 cycles apart -> period_valid with period_out=200; stalled remains 0.
6. Drop enable mid-period, raise it 5 cycles later while sig_in is already high -> no spurious strobe; measurement restarts via ARM; period_out holds its previous value until the next valid measurement.
